// File: rtl/vector_reg_bank_param.sv
// Vector register bank: NUM_REGS x LANES x WIDTH, two combinational read ports,
// masked vector and single-lane immediate writes, and a sequential clear engine.
// Optional same-cycle write forwarding is enabled with `define VRB_WRITE_BYPASS_EN.
module vector_reg_bank_param #(
  parameter int NUM_REGS = 4,
  parameter int LANES    = 4,
  parameter int WIDTH    = 32,
  localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int VEC_W   = LANES * WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [LANES-1:0]  wmask,
  input  logic [IDX_W-1:0]  vd,
  input  logic [VEC_W-1:0]  vw,
  input  logic              write_imm,
  input  logic [LANE_W-1:0] vindex,
  input  logic [WIDTH-1:0]  imm,
  input  logic [IDX_W-1:0]  vs1,
  input  logic [IDX_W-1:0]  vs2,
  output logic [VEC_W-1:0]  v1,
  output logic [VEC_W-1:0]  v2,
  input  logic              clear_req,
  output logic              busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [VEC_W-1:0] regs_q [NUM_REGS];
  logic [VEC_W-1:0] regs_d [NUM_REGS];

  logic             wr_go;
  logic [VEC_W-1:0] wr_vec;

  // Merged image of reg[vd] after this cycle's write; imm overrides the vector lane.
  always_comb begin
    wr_go  = (state_q == ST_IDLE) && (write_enable || write_imm);
    wr_vec = regs_q[vd];
    for (int i = 0; i < LANES; i++) begin
      if (write_enable && wmask[i]) begin
        wr_vec[i*WIDTH +: WIDTH] = vw[i*WIDTH +: WIDTH];
      end
      if (write_imm && (vindex == LANE_W'(i))) begin
        wr_vec[i*WIDTH +: WIDTH] = imm;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    case (state_q)
      ST_IDLE: begin
        if (wr_go) begin
          regs_d[vd] = wr_vec;
        end
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        // Counter wraps back to zero on the final register, ready for the next sequence.
        regs_d[cnt_q] = '0;
        cnt_d         = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(NUM_REGS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  assign busy = (state_q == ST_CLEAR);

`ifdef VRB_WRITE_BYPASS_EN
  assign v1 = (wr_go && (vs1 == vd)) ? wr_vec : regs_q[vs1];
  assign v2 = (wr_go && (vs2 == vd)) ? wr_vec : regs_q[vs2];
`else
  assign v1 = regs_q[vs1];
  assign v2 = regs_q[vs2];
`endif

endmodule

// File: tb/tb_vector_reg_bank_param.sv
// Self-checking bench for vector_reg_bank_param at default parameters (4 regs x 4 lanes x 32 bits).
// Expected register images come from a reference model kept in the bench.
module tb_vector_reg_bank_param;

  localparam int NR = 4;
  localparam int LN = 4;
  localparam int W  = 32;
  localparam int VW = LN * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          write_enable;
  logic [LN-1:0] wmask;
  logic [1:0]    vd;
  logic [VW-1:0] vw;
  logic          write_imm;
  logic [1:0]    vindex;
  logic [W-1:0]  imm;
  logic [1:0]    vs1, vs2;
  logic [VW-1:0] v1, v2;
  logic          clear_req;
  logic          busy;

  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] model [NR];
  int            checks = 0;
  int            errors = 0;

  vector_reg_bank_param #(.NUM_REGS(NR), .LANES(LN), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .write_enable(write_enable), .wmask(wmask), .vd(vd), .vw(vw),
    .write_imm(write_imm), .vindex(vindex), .imm(imm), .vs1(vs1), .vs2(vs2),
    .v1(v1), .v2(v2), .clear_req(clear_req), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    write_enable = 1'b0;
    wmask        = '0;
    vd           = '0;
    vw           = '0;
    write_imm    = 1'b0;
    vindex       = '0;
    imm          = '0;
    clear_req    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [VW-1:0] merge(input logic [VW-1:0] old, input logic we,
                                          input logic [LN-1:0] wm, input logic [VW-1:0] data,
                                          input logic wi, input logic [1:0] idx,
                                          input logic [W-1:0] im);
    logic [VW-1:0] res;
    res = old;
    for (int i = 0; i < LN; i++) begin
      if (we && wm[i]) res[i*W +: W] = data[i*W +: W];
      if (wi && (int'(idx) == i)) res[i*W +: W] = im;
    end
    return res;
  endfunction

  task automatic do_write(input logic we, input logic [LN-1:0] wm, input logic [1:0] d,
                          input logic [VW-1:0] data, input logic wi, input logic [1:0] idx,
                          input logic [W-1:0] im);
    write_enable = we;
    wmask        = wm;
    vd           = d;
    vw           = data;
    write_imm    = wi;
    vindex       = idx;
    imm          = im;
    model[d]     = merge(model[d], we, wm, data, wi, idx, im);
    step();
    drive_idle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [VW-1:0] exp;
    drive_idle();
    rst = 1'b1;
    vs1 = 2'd2;
    vs2 = 2'd1;
    step();
    step();
    rst = 1'b0;
    for (int r = 0; r < NR; r++) model[r] = '0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %0b want 0", busy);
    end
    for (int r = 0; r < NR; r++) begin
      vs1 = 2'(r);
      vs2 = 2'(NR - 1 - r);
      exp_q.push_back(model[r]);
      exp_q.push_back(model[NR - 1 - r]);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (v1 !== exp) begin
        errors++;
        $display("FAIL reset_v1 r=%0d got %h want %h", r, v1, exp);
      end
      exp = exp_q.pop_front();
      checks++;
      if (v2 !== exp) begin
        errors++;
        $display("FAIL reset_v2 r=%0d got %h want %h", NR - 1 - r, v2, exp);
      end
    end
  endtask

  task automatic test_full_write();
    logic [VW-1:0] exp;
    do_write(1'b1, 4'b1111, 2'd1,
             {32'h42AACCCD, 32'h41680000, 32'h41600000, 32'h42080000},
             1'b0, 2'd0, 32'h0);
    exp_q.push_back({32'h42AACCCD, 32'h41680000, 32'h41600000, 32'h42080000});
    vs1 = 2'd1;
    vs2 = 2'd0;
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (v1 !== exp) begin
      errors++;
      $display("FAIL full_write got %h want %h", v1, exp);
    end
    checks++;
    if (v2 !== '0) begin
      errors++;
      $display("FAIL full_write_other got %h want 0", v2);
    end
  endtask

  task automatic test_imm_write();
    logic [VW-1:0] exp;
    do_write(1'b1, 4'b1111, 2'd0,
             {32'h42AA999A, 32'h4261999A, 32'h421E6666, 32'h42DE3333},
             1'b0, 2'd0, 32'h0);
    do_write(1'b0, 4'b0000, 2'd0, '0, 1'b1, 2'd3, 32'h4059999A);
    exp_q.push_back({32'h4059999A, 32'h4261999A, 32'h421E6666, 32'h42DE3333});
    vs1 = 2'd1;
    vs2 = 2'd0;
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (v2 !== exp) begin
      errors++;
      $display("FAIL imm_write got %h want %h", v2, exp);
    end
  endtask

  task automatic test_masked_combo();
    logic [VW-1:0] exp;
    do_write(1'b1, 4'b0101, 2'd2, {LN{32'hFFFFFFFF}}, 1'b0, 2'd0, 32'h0);
    exp_q.push_back({32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF});
    vs1 = 2'd2;
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (v1 !== exp) begin
      errors++;
      $display("FAIL masked_write got %h want %h", v1, exp);
    end
    // Combined write on reg3 from zero: imm lane 1 lands even though wmask[1]=0.
    do_write(1'b1, 4'b0101, 2'd3, {LN{32'hFFFFFFFF}}, 1'b1, 2'd1, 32'h3F800000);
    exp_q.push_back({32'h00000000, 32'hFFFFFFFF, 32'h3F800000, 32'hFFFFFFFF});
    vs1 = 2'd3;
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (v1 !== exp) begin
      errors++;
      $display("FAIL combo_imm_unmasked got %h want %h", v1, exp);
    end
    // Imm lane 0 with wmask[0]=1: imm still wins.
    do_write(1'b1, 4'b0011, 2'd2, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444},
             1'b1, 2'd0, 32'hCAFEF00D);
    exp_q.push_back({32'h00000000, 32'hFFFFFFFF, 32'h33333333, 32'hCAFEF00D});
    vs2 = 2'd2;
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (v2 !== exp) begin
      errors++;
      $display("FAIL combo_imm_masked got %h want %h", v2, exp);
    end
  endtask

  task automatic test_bypass();
    logic [VW-1:0] exp;
    logic [VW-1:0] newv;
    logic [VW-1:0] merged;
    newv   = {32'hA5A5A5A5, 32'h5A5A5A5A, 32'h01234567, 32'h89ABCDEF};
    merged = merge(model[3], 1'b1, 4'b0011, newv, 1'b0, 2'd0, 32'h0);
    write_enable = 1'b1;
    wmask        = 4'b0011;
    vd           = 2'd3;
    vw           = newv;
    vs1          = 2'd3;
    vs2          = 2'd1;
`ifdef VRB_WRITE_BYPASS_EN
    exp_q.push_back(merged);
`else
    exp_q.push_back(model[3]);
`endif
    exp_q.push_back(model[1]);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (v1 !== exp) begin
      errors++;
      $display("FAIL bypass_same_cycle got %h want %h", v1, exp);
    end
    exp = exp_q.pop_front();
    checks++;
    if (v2 !== exp) begin
      errors++;
      $display("FAIL bypass_other_reg got %h want %h", v2, exp);
    end
    model[3] = merged;
    step();
    drive_idle();
    exp_q.push_back(model[3]);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (v1 !== exp) begin
      errors++;
      $display("FAIL bypass_next_cycle got %h want %h", v1, exp);
    end
  endtask

  task automatic test_clear();
    logic [VW-1:0] exp;
    int busy_cycles;
    do_write(1'b1, 4'b1111, 2'd3, {32'hDEADBEEF, 32'h0BADF00D, 32'h12345678, 32'h9ABCDEF0},
             1'b0, 2'd0, 32'h0);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    busy_cycles = 0;
    for (int c = 0; c < 12 && busy === 1'b1; c++) begin
      busy_cycles++;
      if (c == 2) begin
        vs1 = 2'd0;
        vs2 = 2'd3;
        exp_q.push_back(model[0]);
        exp_q.push_back(model[3]);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (v1 !== exp) begin
          errors++;
          $display("FAIL clear_mid_cleared got %h want %h", v1, exp);
        end
        exp = exp_q.pop_front();
        checks++;
        if (v2 !== exp) begin
          errors++;
          $display("FAIL clear_mid_pending got %h want %h", v2, exp);
        end
      end
      write_enable = 1'b1;
      wmask        = 4'b1111;
      vd           = 2'(c % NR);
      vw           = {$urandom, $urandom, $urandom, $urandom};
      write_imm    = 1'b1;
      vindex       = 2'(c % LN);
      imm          = $urandom;
      clear_req    = 1'b1;
      if (c < NR) model[c] = '0;
      step();
    end
    drive_idle();
    checks++;
    if (busy_cycles != NR) begin
      errors++;
      $display("FAIL clear_busy_cycles got %0d want %0d", busy_cycles, NR);
    end
    for (int r = 0; r < NR; r++) begin
      vs1 = 2'(r);
      exp_q.push_back(model[r]);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (v1 !== exp) begin
        errors++;
        $display("FAIL clear_after r=%0d got %h want %h", r, v1, exp);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [VW-1:0] exp;
    for (int r = 0; r < NR; r++) begin
      do_write(1'b1, 4'b1111, 2'(r), {$urandom, $urandom, $urandom, $urandom} | 128'h1,
               1'b0, 2'd0, 32'h0);
    end
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    step();
    rst          = 1'b1;
    write_enable = 1'b1;
    wmask        = 4'b1111;
    vd           = 2'd3;
    vw           = {LN{32'hFFFFFFFF}};
    step();
    rst = 1'b0;
    drive_idle();
    for (int r = 0; r < NR; r++) model[r] = '0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_clear_busy got %0b want 0", busy);
    end
    for (int r = 0; r < NR; r++) begin
      vs2 = 2'(r);
      exp_q.push_back(model[r]);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (v2 !== exp) begin
        errors++;
        $display("FAIL rst_mid_clear r=%0d got %h want %h", r, v2, exp);
      end
    end
    // A write right after the abort must land, proving the engine is idle.
    do_write(1'b1, 4'b1111, 2'd2, {32'h1, 32'h2, 32'h3, 32'h4}, 1'b0, 2'd0, 32'h0);
    vs1 = 2'd2;
    exp_q.push_back(model[2]);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if (v1 !== exp) begin
      errors++;
      $display("FAIL rst_mid_clear_write got %h want %h", v1, exp);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] exp;
    logic [1:0]    d;
    logic [1:0]    other;
    for (int n = 0; n < 40; n++) begin
      d = 2'($urandom_range(0, NR - 1));
      do_write(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), d,
               {$urandom, $urandom, $urandom, $urandom},
               1'($urandom_range(0, 1)), 2'($urandom_range(0, LN - 1)), $urandom);
      other = 2'($urandom_range(0, NR - 1));
      vs1   = d;
      vs2   = other;
      exp_q.push_back(model[d]);
      exp_q.push_back(model[other]);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (v1 !== exp) begin
        errors++;
        $display("FAIL random_v1 n=%0d reg=%0d got %h want %h", n, d, v1, exp);
      end
      exp = exp_q.pop_front();
      checks++;
      if (v2 !== exp) begin
        errors++;
        $display("FAIL random_v2 n=%0d reg=%0d got %h want %h", n, other, v2, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    vs1 = '0;
    vs2 = '0;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_full_write();
    test_imm_write();
    test_masked_combo();
    test_bypass();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_reg_bank_param.md
VECTOR_REG_BANK_PARAM -- requirements
Module: vector_reg_bank_param

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of vector registers (power of two, >=2).
REQ-002 SHALL have parameter LANES, default 4, number of lanes per vector register.
REQ-003 SHALL have parameter WIDTH, default 32, bits per lane (IEEE-754 single at default).
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port write_enable  input  1  full-vector write request to register vd.
REQ-007 SHALL have port wmask  input  LANES  per-lane write enable for write_enable.
REQ-008 SHALL have port vd  input  log2(NUM_REGS)  destination register index.
REQ-009 SHALL have port vw  input  LANES*WIDTH  write data, lane i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port write_imm  input  1  single-lane immediate write to register vd.
REQ-011 SHALL have port vindex  input  log2(LANES)  lane selected by write_imm.
REQ-012 SHALL have port imm  input  WIDTH  immediate data.
REQ-013 SHALL have ports vs1, vs2  input  log2(NUM_REGS) each  read register indices.
REQ-014 SHALL have ports v1, v2  output  LANES*WIDTH each  read data for vs1, vs2, same lane packing as vw.
REQ-015 SHALL have port clear_req  input  1  request to zero every register.
REQ-016 SHALL have port busy  output  1  high while clear sequence runs.

Function
REQ-017 SHALL provide combinational reads: v1/v2 reflect stored contents of vs1/vs2 in the same cycle.
REQ-018 SHALL, on a rising edge with write_enable=1 and busy=0, write vw lane i into reg[vd] lane i for every i with wmask[i]=1; lanes with wmask[i]=0 unchanged.
REQ-019 SHALL, on a rising edge with write_imm=1 and busy=0, write imm into reg[vd] lane vindex, other lanes unchanged.
REQ-020 SHALL, when write_enable and write_imm are both 1, apply both; lane vindex takes imm regardless of wmask[vindex].
REQ-021 SHALL implement clear FSM with states IDLE and CLEAR and a log2(NUM_REGS)-bit counter.
REQ-022 SHALL, in IDLE with clear_req=1, go to CLEAR with counter=0 at next edge; busy=1 from that edge.
REQ-023 SHALL, in CLEAR, zero all lanes of reg[counter] each edge and increment counter; after zeroing reg[NUM_REGS-1] return to IDLE, busy=0 (NUM_REGS cycles total).
REQ-024 SHALL ignore write_enable, write_imm and clear_req while busy=1.
REQ-025 SHALL, in CLEAR, return current stored contents on reads (not-yet-cleared registers keep old values).
REQ-026 SHALL wrap counter naturally; no register is cleared twice per sequence.

Reset
REQ-027 SHALL, on rising edge with rst=1, zero every lane of every register, set state IDLE, counter 0, busy 0.
REQ-028 SHALL give rst priority over clear_req and all writes, including mid-CLEAR (sequence aborted, all registers zeroed).
REQ-029 SHALL, therefore, present v1=v2=0 in the cycle after reset for any vs1/vs2.

Configuration
REQ-030 SHALL support macro VRB_WRITE_BYPASS_EN.
REQ-031 SHALL, with VRB_WRITE_BYPASS_EN defined, forward same-cycle write data to v1/v2: if busy=0 and vs equals vd, lanes being written (per REQ-018..020) show incoming vw/imm, others show stored value.
REQ-032 SHALL, without VRB_WRITE_BYPASS_EN, show only stored contents; written data visible from the cycle after the edge.

Verification
REQ-033 SHALL cover: reset, then vd=1, write_enable=1, wmask=1111, vw lanes {0x42080000,0x41600000,0x41680000,0x42AACCCD} -> vs1=1 gives those lanes next cycle.
REQ-034 SHALL cover: reg0 holds {0x42DE3333,0x421E6666,0x4261999A,0x42AA999A}; write_imm=1, vd=0, vindex=3, imm=0x4059999A -> lane3=0x4059999A, lanes 0-2 unchanged.
REQ-035 SHALL cover: wmask=0101 write of all-0xFFFFFFFF to reg2 holding zeros -> lanes 0,2=0xFFFFFFFF, lanes 1,3=0; simultaneous write_imm vindex=1 imm=0x3F800000 -> lane1=0x3F800000.
REQ-036 SHALL cover: clear_req pulse with NUM_REGS=4 -> busy high exactly 4 cycles; write_enable during busy has no effect; all registers 0 afterwards.
REQ-037 SHALL cover: rst asserted in second CLEAR cycle -> busy=0 and all registers 0 next cycle.
REQ-038 SHALL cover: vs1=vd=3 with write_enable=1 -> v1 equals vw in same cycle with VRB_WRITE_BYPASS_EN, old value without.
